// File: rtl/noc_out_port_arbiter_mux.sv
// Switch output-port stage: round-robin arbitration over N input flit channels
// with wormhole locking until the tail flit, feeding a registered, stallable output.
module noc_out_port_arbiter_mux #(
  parameter  int N_INPUTS   = 3,
  parameter  int FLIT_WIDTH = 80,
  localparam int PTR_W      = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_INPUTS*FLIT_WIDTH-1:0] flit_in,
  input  logic [N_INPUTS-1:0]            req_in,
  input  logic [N_INPUTS-1:0]            tail_in,
  input  logic                           stall_in,
  output logic [N_INPUTS-1:0]            grant_out,
  output logic [FLIT_WIDTH-1:0]          flit_out,
  output logic                           valid_out
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                  state;
  logic [PTR_W-1:0]        rr_ptr;
  logic [PTR_W-1:0]        owner;

  logic                    load_en;
  logic                    grant_any;
  logic [PTR_W-1:0]        grant_idx;
  logic                    grant_tail;
  logic [PTR_W-1:0]        ptr_next;
  logic [FLIT_WIDTH-1:0]   flit_sel;
  int                      cand;

  // The output register accepts a new flit when empty or when its flit leaves this cycle.
  assign load_en = !valid_out || !stall_in;

  // NOTE: every signal written in this block gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_out = '0;
    cand      = 0;
    if (!rst && load_en) begin
      if (state == LOCKED) begin
        if (req_in[owner]) begin
          grant_any = 1'b1;
          grant_idx = owner;
        end
      end else begin
        // Walk downward so the requester closest above rr_ptr is the last to win.
        for (int k = N_INPUTS - 1; k >= 0; k--) begin
          cand = int'(rr_ptr) + k;
          if (cand >= N_INPUTS) cand = cand - N_INPUTS;
          if (req_in[cand]) begin
            grant_any = 1'b1;
            grant_idx = PTR_W'(cand);
          end
        end
      end
    end
    if (grant_any) grant_out[grant_idx] = 1'b1;
  end

  // One-hot AND-OR select; an idle cycle yields an all-zero flit.
  always_comb begin
    flit_sel = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (grant_out[i]) flit_sel = flit_sel | flit_in[i*FLIT_WIDTH +: FLIT_WIDTH];
    end
  end

  assign grant_tail = grant_any && tail_in[grant_idx];
  assign ptr_next   = (int'(grant_idx) == N_INPUTS - 1) ? '0 : grant_idx + 1'b1;

  // NOTE: state is updated with non-blocking assignments only, so every register
  // samples values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      valid_out <= 1'b0;
      flit_out  <= '0;
    end else begin
      if (load_en) begin
        valid_out <= grant_any;
        flit_out  <= flit_sel;
      end
      if (grant_any) begin
        if (grant_tail) begin
          state  <= IDLE;
          rr_ptr <= ptr_next;
        end else begin
          state <= LOCKED;
          owner <= grant_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_out_port_arbiter_mux.sv
// Self-checking bench: directed vector table on a 3x80 instance, then wrap and
// randomized traffic on a 5x32 instance checked against a queue-free reference model.
module tb_noc_out_port_arbiter_mux;

  localparam int N3 = 3;
  localparam int W3 = 80;
  localparam int N5 = 5;
  localparam int W5 = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst3, stall3, vout3;
  logic [N3-1:0]     req3, tail3, grant3;
  logic [N3*W3-1:0]  flit3;
  logic [W3-1:0]     fout3;

  logic              rst5, stall5, vout5;
  logic [N5-1:0]     req5, tail5, grant5;
  logic [N5*W5-1:0]  flit5;
  logic [W5-1:0]     fout5;

  noc_out_port_arbiter_mux #(.N_INPUTS(N3), .FLIT_WIDTH(W3)) dut3 (
    .clk(clk), .rst(rst3), .flit_in(flit3), .req_in(req3), .tail_in(tail3),
    .grant_out(grant3), .flit_out(fout3), .valid_out(vout3), .stall_in(stall3)
  );

  noc_out_port_arbiter_mux #(.N_INPUTS(N5), .FLIT_WIDTH(W5)) dut5 (
    .clk(clk), .rst(rst5), .flit_in(flit5), .req_in(req5), .tail_in(tail5),
    .grant_out(grant5), .flit_out(fout5), .valid_out(vout5), .stall_in(stall5)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- 3-input directed table ----------------
  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic [2:0] tail;
    logic       stall;
    logic [7:0] fseq;
    logic [2:0] exp_grant;
    logic       exp_valid;
    int         exp_ch;
    logic [7:0] exp_seq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic r, logic [2:0] rq, logic [2:0] tl, logic st, int fs,
                               logic [2:0] eg, logic ev, int ech, int es);
    vec_t t;
    t.rst = r; t.req = rq; t.tail = tl; t.stall = st; t.fseq = 8'(fs);
    t.exp_grant = eg; t.exp_valid = ev; t.exp_ch = ech; t.exp_seq = 8'(es);
    return t;
  endfunction

  function automatic logic [W3-1:0] mk3(int ch, logic [7:0] seq);
    return {8'(ch), 64'h0123_4567_89AB_CDEF, seq};
  endfunction

  function automatic logic [W5-1:0] mk5(int ch, int pkt, int seq);
    return {4'(ch), 12'(pkt), 16'(seq)};
  endfunction

  // ---------------- 5-input reference model state ----------------
  int src_pkt[N5], src_seq[N5], src_left[N5], out_next[N5];
  int m_owner, m_ptr;
  logic m_valid;
  logic [W5-1:0] m_flit;

  task automatic drive5_from_sources();
    for (int i = 0; i < N5; i++) begin
      flit5[i*W5 +: W5] = mk5(i, src_pkt[i], src_seq[i]);
      tail5[i] = (src_left[i] == 1);
      req5[i]  = ($urandom_range(0, 3) != 0);
    end
    stall5 = ($urandom_range(0, 3) == 0);
  endtask

  task automatic model_step(input int cyc);
    int g;
    int id;
    logic [N5-1:0] eg;
    g = -1;
    if (!m_valid || !stall5) begin
      if (m_owner >= 0) begin
        if (req5[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < N5; k++) begin
          int c;
          c = (m_ptr + k) % N5;
          if (req5[c] && g < 0) g = c;
        end
      end
    end
    eg = (g < 0) ? '0 : (N5'(1) << g);
    check($sformatf("rnd%0d grant", cyc), grant5, eg);
    check($sformatf("rnd%0d valid", cyc), vout5, m_valid);
    check($sformatf("rnd%0d flit", cyc), fout5, m_flit);
    // Per-input ordering as seen downstream.
    if (vout5 && !stall5) begin
      id = int'(fout5[31:28]);
      if (id < N5) begin
        check($sformatf("rnd%0d order in%0d", cyc, id), fout5[15:0], 16'(out_next[id]));
        out_next[id]++;
      end else begin
        check($sformatf("rnd%0d source id", cyc), fout5[31:28], 4'(N5 - 1));
      end
    end
    if (g >= 0) begin
      m_flit  = mk5(g, src_pkt[g], src_seq[g]);
      m_valid = 1'b1;
      if (src_left[g] == 1) begin
        m_owner = -1;
        m_ptr   = (g + 1) % N5;
      end else begin
        m_owner = g;
      end
      src_seq[g]++;
      src_left[g]--;
      if (src_left[g] == 0) begin
        src_pkt[g]++;
        src_left[g] = $urandom_range(1, 4);
      end
    end else if (!m_valid || !stall5) begin
      m_valid = 1'b0;
      m_flit  = '0;
    end
  endtask

  initial begin
    rst3 = 1'b1; req3 = '0; tail3 = '0; stall3 = 1'b0; flit3 = '0;
    rst5 = 1'b1; req5 = '0; tail5 = '0; stall5 = 1'b0; flit5 = '0;

    // Round robin, 4-flit wormhole, stall hold, owner gap, reset mid-packet.
    vecs.push_back(mkv(1, 3'b111, 3'b111, 0,  0, 3'b000, 0, -1,  0));
    vecs.push_back(mkv(0, 3'b111, 3'b111, 0,  1, 3'b001, 0, -1,  0));
    vecs.push_back(mkv(0, 3'b111, 3'b111, 0,  2, 3'b010, 1,  0,  1));
    vecs.push_back(mkv(0, 3'b111, 3'b111, 0,  3, 3'b100, 1,  1,  2));
    vecs.push_back(mkv(0, 3'b111, 3'b111, 0,  4, 3'b001, 1,  2,  3));
    vecs.push_back(mkv(0, 3'b111, 3'b101, 0,  5, 3'b010, 1,  0,  4));
    vecs.push_back(mkv(0, 3'b111, 3'b101, 0,  6, 3'b010, 1,  1,  5));
    vecs.push_back(mkv(0, 3'b111, 3'b101, 0,  7, 3'b010, 1,  1,  6));
    vecs.push_back(mkv(0, 3'b111, 3'b111, 0,  8, 3'b010, 1,  1,  7));
    vecs.push_back(mkv(0, 3'b111, 3'b111, 0,  9, 3'b100, 1,  1,  8));
    vecs.push_back(mkv(0, 3'b111, 3'b111, 0, 10, 3'b001, 1,  2,  9));
    vecs.push_back(mkv(0, 3'b111, 3'b101, 0, 11, 3'b010, 1,  0, 10));
    vecs.push_back(mkv(0, 3'b111, 3'b101, 0, 12, 3'b010, 1,  1, 11));
    vecs.push_back(mkv(0, 3'b111, 3'b101, 1, 13, 3'b000, 1,  1, 12));
    vecs.push_back(mkv(0, 3'b111, 3'b101, 1, 13, 3'b000, 1,  1, 12));
    vecs.push_back(mkv(0, 3'b111, 3'b101, 1, 13, 3'b000, 1,  1, 12));
    vecs.push_back(mkv(0, 3'b111, 3'b111, 0, 13, 3'b010, 1,  1, 12));
    vecs.push_back(mkv(0, 3'b111, 3'b111, 0, 17, 3'b100, 1,  1, 13));
    vecs.push_back(mkv(0, 3'b111, 3'b110, 0, 18, 3'b001, 1,  2, 17));
    vecs.push_back(mkv(0, 3'b110, 3'b110, 0, 19, 3'b000, 1,  0, 18));
    vecs.push_back(mkv(0, 3'b110, 3'b110, 0, 20, 3'b000, 0, -1,  0));
    vecs.push_back(mkv(0, 3'b111, 3'b111, 0, 21, 3'b001, 0, -1,  0));
    vecs.push_back(mkv(0, 3'b111, 3'b111, 0, 22, 3'b010, 1,  0, 21));
    vecs.push_back(mkv(0, 3'b111, 3'b011, 0, 23, 3'b100, 1,  1, 22));
    vecs.push_back(mkv(1, 3'b111, 3'b011, 0, 24, 3'b000, 1,  2, 23));
    vecs.push_back(mkv(0, 3'b110, 3'b111, 0, 25, 3'b010, 0, -1,  0));
    vecs.push_back(mkv(0, 3'b000, 3'b111, 0, 26, 3'b000, 1,  1, 25));
    vecs.push_back(mkv(0, 3'b000, 3'b111, 0, 27, 3'b000, 0, -1,  0));

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      logic [W3-1:0] ef;
      rst3 = vecs[i].rst; req3 = vecs[i].req; tail3 = vecs[i].tail; stall3 = vecs[i].stall;
      for (int c = 0; c < N3; c++) flit3[c*W3 +: W3] = mk3(c, vecs[i].fseq);
      ef = (vecs[i].exp_ch < 0) ? '0 : mk3(vecs[i].exp_ch, vecs[i].exp_seq);
      @(negedge clk);
      check($sformatf("vec%0d grant", i), grant3, vecs[i].exp_grant);
      check($sformatf("vec%0d valid", i), vout3, vecs[i].exp_valid);
      check($sformatf("vec%0d flit", i), fout3, ef);
      @(posedge clk);
      #1;
    end
    rst3 = 1'b1; req3 = '0;

    // 5 inputs, only ends of the range requesting: pointer must wrap 4 -> 0.
    req5 = 5'b10001; tail5 = '1; stall5 = 1'b0; rst5 = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      for (int c = 0; c < N5; c++) flit5[c*W5 +: W5] = mk5(c, 0, cyc);
      @(negedge clk);
      check($sformatf("wrap%0d grant", cyc), grant5, (cyc % 2 == 0) ? 5'b00001 : 5'b10000);
      if (cyc > 0) begin
        check($sformatf("wrap%0d valid", cyc), vout5, 1'b1);
        check($sformatf("wrap%0d flit", cyc), fout5,
              mk5((cyc % 2 == 1) ? 0 : 4, 0, cyc - 1));
      end
      @(posedge clk);
      #1;
    end

    // Randomized traffic from a fresh reset.
    rst5 = 1'b1; req5 = '0;
    @(posedge clk);
    #1;
    rst5 = 1'b0;
    m_owner = -1; m_ptr = 0; m_valid = 1'b0; m_flit = '0;
    for (int i = 0; i < N5; i++) begin
      src_pkt[i] = 0; src_seq[i] = 0; out_next[i] = 0;
      src_left[i] = $urandom_range(1, 4);
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      drive5_from_sources();
      @(negedge clk);
      model_step(cyc);
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
